uart_rx_fifo: RTL and testbench

//  Receive-side buffer sitting directly downstream of the UART receiver. Captures each

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: parity encodings and default frame/oversampling settings.
// Used by the transmitter, receiver, baud generator and the receive FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  localparam int DEFAULT_DATA_WD    = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  function automatic parity_e decode_parity(input logic [1:0] enc);
    case (enc)
      2'd1:    return PARITY_ODD;
      2'd2:    return PARITY_EVEN;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x DATA_WD first-word-fall-through FIFO.
// A registered head word is loaded from the array or bypassed from the write port.
module uart_sync_fifo #(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [DATA_WD-1:0]         i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_WD-1:0]         o_rd_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_WD-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [DATA_WD-1:0] r_rd_data;

  logic               w_empty;
  logic               w_full;
  logic               w_wr;
  logic               w_rd;
  logic [PW-1:0]      w_rd_ptr_next;
  logic [PW-1:0]      w_diff;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = i_rd_en & ~w_empty;
  // A simultaneous pop frees a slot, so a write into a full FIFO is legal then.
  assign w_wr    = i_wr_en & (~w_full | w_rd);

  assign w_rd_ptr_next = w_rd ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
  assign w_diff        = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      // New head is either the word being written now or one already in the array;
      // when the FIFO drains the head keeps its last value.
      if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
        r_rd_data <= i_wr_data;
      end else if (w_rd_ptr_next != r_wr_ptr) begin
        r_rd_data <= r_mem[w_rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_level   = LW'(w_diff);

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per rx_done rising edge, sticky overrun flag.
// Define UART_RX_FIFO_ERR_CNT_EN to add saturating framing/parity error counters.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WD  = DEFAULT_DATA_WD,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int CNT_WD   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_done,
  input  logic [DATA_WD-1:0]         rx_dout,
  input  logic                       rx_frame_err,
  input  logic                       rx_parity_err,
  input  logic                       rd_en,
  output logic [DATA_WD-1:0]         rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overrun,
`ifdef UART_RX_FIFO_ERR_CNT_EN
  output logic [CNT_WD-1:0]          frame_err_cnt,
  output logic [CNT_WD-1:0]          parity_err_cnt,
  input  logic                       err_cnt_clr,
`endif
  input  logic                       ovr_clr
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] AF_LVL = LW'(AF_LEVEL);

  logic r_rx_done_q;
  logic r_overrun;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_push = rx_done & ~r_rx_done_q;
  assign w_pop  = rd_en & ~empty;
  assign w_drop = w_push & full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_done_q <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  uart_sync_fifo #(
    .DATA_WD (DATA_WD),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (rx_dout),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_level   (level)
  );

  assign almost_full = (level >= AF_LVL);
  assign overrun     = r_overrun;

`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic              r_frame_err_q;
  logic              r_parity_err_q;
  logic [CNT_WD-1:0] r_frame_err_cnt;
  logic [CNT_WD-1:0] r_parity_err_cnt;
  logic              w_frame_evt;
  logic              w_parity_evt;

  assign w_frame_evt  = rx_frame_err & ~r_frame_err_q;
  assign w_parity_evt = rx_parity_err & ~r_parity_err_q;

  // A clear coinciding with an event leaves the event counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err_q    <= 1'b0;
      r_parity_err_q   <= 1'b0;
      r_frame_err_cnt  <= '0;
      r_parity_err_cnt <= '0;
    end else begin
      r_frame_err_q  <= rx_frame_err;
      r_parity_err_q <= rx_parity_err;
      if (err_cnt_clr) begin
        r_frame_err_cnt <= w_frame_evt ? CNT_WD'(1) : '0;
      end else if (w_frame_evt && (r_frame_err_cnt != {CNT_WD{1'b1}})) begin
        r_frame_err_cnt <= r_frame_err_cnt + CNT_WD'(1);
      end
      if (err_cnt_clr) begin
        r_parity_err_cnt <= w_parity_evt ? CNT_WD'(1) : '0;
      end else if (w_parity_evt && (r_parity_err_cnt != {CNT_WD{1'b1}})) begin
        r_parity_err_cnt <= r_parity_err_cnt + CNT_WD'(1);
      end
    end
  end

  assign frame_err_cnt  = r_frame_err_cnt;
  assign parity_err_cnt = r_parity_err_cnt;
`else
  logic w_unused;
  assign w_unused = &{1'b0, rx_frame_err, rx_parity_err, CNT_WD[0]};
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames push expected bytes, a monitor checks pops.
// Error-counter checks run only when UART_RX_FIFO_ERR_CNT_EN is defined.
module tb_uart_rx_fifo;

  localparam int DATA_WD = 8;
  localparam int DEPTH   = 16;
  localparam int CNT_WD  = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_done;
  logic [DATA_WD-1:0] rx_dout;
  logic               rx_frame_err;
  logic               rx_parity_err;
  logic               rd_en;
  logic [DATA_WD-1:0] rd_data;
  logic               empty;
  logic               full;
  logic               almost_full;
  logic [4:0]         level;
  logic               overrun;
  logic               ovr_clr;
`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic [CNT_WD-1:0]  frame_err_cnt;
  logic [CNT_WD-1:0]  parity_err_cnt;
  logic               err_cnt_clr;
`endif

  int errors = 0;
  int checks = 0;
  logic [DATA_WD-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WD  (DATA_WD),
    .DEPTH    (DEPTH),
    .AF_LEVEL (12),
    .CNT_WD   (CNT_WD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_done        (rx_done),
    .rx_dout        (rx_dout),
    .rx_frame_err   (rx_frame_err),
    .rx_parity_err  (rx_parity_err),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .level          (level),
    .overrun        (overrun),
`ifdef UART_RX_FIFO_ERR_CNT_EN
    .frame_err_cnt  (frame_err_cnt),
    .parity_err_cnt (parity_err_cnt),
    .err_cnt_clr    (err_cnt_clr),
`endif
    .ovr_clr        (ovr_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Pops are committed on the next rising edge, so the head is sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", rd_data);
      end else begin
        check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data is changed after the first high cycle so only the edge-cycle value may be captured.
  task automatic send_frame(input logic [DATA_WD-1:0] d, input int hold);
    rx_dout = d;
    rx_done = 1'b1;
    step();
    rx_dout = ~d;
    repeat (hold - 1) step();
    rx_done = 1'b0;
    step();
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) step();
    rd_en = 1'b0;
  endtask

  task automatic err_pulse(input bit parity, input int hold);
    if (parity) rx_parity_err = 1'b1; else rx_frame_err = 1'b1;
    repeat (hold) step();
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_dout = '0; rx_frame_err = 1'b0;
    rx_parity_err = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
`ifdef UART_RX_FIFO_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rd_data", 32'(rd_data), 0);

    // Three frames, drained in order
    send_frame(8'h55, 2);
    send_frame(8'hA3, 2);
    send_frame(8'h0F, 2);
    check("t1_level", 32'(level), 3);
    check("t1_head", 32'(rd_data), 32'h55);
    pop_n(3);
    check("t1_empty", 32'(empty), 1);
    check("t1_hold_last", 32'(rd_data), 32'h0F);

    // Fill to 16, drop the 17th, clear overrun
    for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 2);
    check("t2_full", 32'(full), 1);
    check("t2_level16", 32'(level), 16);
    check("t2_no_ovr_yet", 32'(overrun), 0);
    send_frame(8'hEE, 2);
    check("t2_overrun", 32'(overrun), 1);
    check("t2_level_kept", 32'(level), 16);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t2_ovr_clr", 32'(overrun), 0);

    // Full: push and pop together
    rx_dout = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
    step();
    exp_q.push_back(8'h77);
    rd_en = 1'b0; rx_done = 1'b0;
    step();
    check("t3_level", 32'(level), 16);
    check("t3_overrun", 32'(overrun), 0);
    pop_n(16);
    check("t3_empty", 32'(empty), 1);
    check("t3_last", 32'(rd_data), 32'h77);

    // Empty: read request with a simultaneous push
    rd_en = 1'b1; rx_dout = 8'h3C; rx_done = 1'b1;
    step();
    rd_en = 1'b0; rx_done = 1'b0;
    exp_q.push_back(8'h3C);
    check("t4_level", 32'(level), 1);
    check("t4_rd_data", 32'(rd_data), 32'h3C);
    step();
    pop_n(1);
    check("t4_empty", 32'(empty), 1);

    // almost_full threshold; first frame held long to confirm a single push
    send_frame(8'hB0, 5);
    check("t5_long_frame_level", 32'(level), 1);
    for (int i = 1; i < 11; i++) send_frame(8'(8'hB0 + i), 2);
    check("t5_af_11", 32'(almost_full), 0);
    send_frame(8'hBB, 2);
    check("t5_af_12", 32'(almost_full), 1);
    pop_n(1);
    check("t5_af_pop", 32'(almost_full), 0);
    pop_n(11);
    check("t5_empty", 32'(empty), 1);

    // Error pulses never push data
    for (int i = 0; i < 3; i++) err_pulse(1'b0, 2);
    err_pulse(1'b1, 2);
    check("t6_no_push", 32'(level), 0);
`ifdef UART_RX_FIFO_ERR_CNT_EN
    check("t6_frame_cnt", 32'(frame_err_cnt), 3);
    check("t6_parity_cnt", 32'(parity_err_cnt), 1);
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    check("t6_clr", 32'(frame_err_cnt), 0);
    for (int i = 0; i < 256; i++) err_pulse(1'b0, 1);
    check("t6_saturate", 32'(frame_err_cnt), 255);
    err_cnt_clr = 1'b1; rx_frame_err = 1'b1;
    step();
    err_cnt_clr = 1'b0; rx_frame_err = 1'b0;
    check("t6_clr_evt", 32'(frame_err_cnt), 1);
`endif

    // Reset in the middle of a frame with the FIFO full and overrun set
    for (int i = 0; i < 17; i++) send_frame(8'(8'h80 + i), 2);
    check("t6_pre_ovr", 32'(overrun), 1);
    rx_dout = 8'h99; rx_done = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_async_level", 32'(level), 0);
    check("t6_async_empty", 32'(empty), 1);
    check("t6_async_full", 32'(full), 0);
    check("t6_async_af", 32'(almost_full), 0);
    check("t6_async_ovr", 32'(overrun), 0);
    check("t6_async_rd", 32'(rd_data), 0);
`ifdef UART_RX_FIFO_ERR_CNT_EN
    check("t6_async_fcnt", 32'(frame_err_cnt), 0);
`endif
    rx_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_frame(8'hC5, 2);
    check("t6_post_level", 32'(level), 1);
    check("t6_post_rd", 32'(rd_data), 32'hC5);
    pop_n(1);
    check("t6_post_empty", 32'(empty), 1);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
